booth_division: RTL and testbench

//  Sequential signed integer divider; the inverse operation of the ALU's Booth

---
 rtl/booth_division.sv | 140 ++++++++++++++
 tb/tb_booth_division.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/booth_division.sv
// Sequential signed divider: non-restoring magnitude division, one quotient bit
// per clock, followed by a sign/remainder fix-up cycle and a one-cycle done pulse.
module booth_division #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   m_q;
  logic             sd_q, sv_q, ovf_pend_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             dbz_q, ovf_q;

  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic             div_zero;
  logic [WIDTH:0]   a_sh, a_step;
  logic [WIDTH-1:0] rem_mag, q_res, r_res;

  // |MOST_NEG| comes out as 2**(WIDTH-1) read unsigned, so no extra bit is needed here
  assign dvd_abs  = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign div_zero = (divisor == '0);

  assign a_sh    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign a_step  = a_sh[WIDTH] ? (a_sh + m_q) : (a_sh - m_q);
  // Final remainder magnitude is below |divisor|, so the low WIDTH bits suffice
  assign rem_mag = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q[WIDTH-1:0]) : a_q[WIDTH-1:0];
  assign q_res   = (sd_q ^ sv_q) ? -q_q : q_q;
  assign r_res   = sd_q ? -rem_mag : rem_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = div_zero ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (count_q == LAST) state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      sd_q        <= 1'b0;
      sv_q        <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
            end else begin
              count_q    <= '0;
              a_q        <= '0;
              q_q        <= dvd_abs;
              m_q        <= {1'b0, dvs_abs};
              sd_q       <= dividend[WIDTH-1];
              sv_q       <= divisor[WIDTH-1];
              ovf_pend_q <= (dividend == MOST_NEG) && (divisor == '1);
            end
          end
        end
        CALC: begin
          a_q     <= a_step;
          q_q     <= {q_q[WIDTH-2:0], ~a_step[WIDTH]};
          count_q <= count_q + 1'b1;
        end
        FIX: begin
          quotient_q  <= q_res;
          remainder_q <= r_res;
          dbz_q       <= 1'b0;
          ovf_q       <= ovf_pend_q;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_division.sv
// Directed-vector bench for booth_division: table of hand-computed results,
// handshake corner sequences and a short randomized sweep against an integer model.
module tb_booth_division;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend, divisor;
  logic [7:0] quotient, remainder;
  logic       busy, done, div_by_zero, overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] prev_q = '0;
  logic [7:0] prev_r = '0;

  booth_division #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dbz, output logic ovf);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = 8'hFF; r = a; dbz = 1'b1; ovf = 1'b0;
    end else begin
      q = 8'(sa / sb); r = 8'(sa % sb); dbz = 1'b0;
      ovf = (sa == -128) && (sb == -1);
    end
  endfunction

  // One operation: start in an IDLE cycle, track latency/busy, check results
  // and the one-cycle done pulse. poke re-asserts start while busy.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edbz, input logic eovf, input bit poke);
    int lat, busy_n;
    bit first;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat = 1; busy_n = 0; first = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (first) check({tag, " hold"}, {quotient, remainder}, {prev_q, prev_r});
      first = 1'b0;
      if (poke && lat >= 2 && lat <= 4) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, (b == 8'd0) ? 10'd1 : 10'd10);
    check({tag, " busy cycles"}, busy_n, (b == 8'd0) ? 0 : 9);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, edbz);
    check({tag, " overflow"}, overflow, eovf);
    prev_q = eq; prev_r = er;
    @(posedge clk); #1;
    check({tag, " done pulse"}, {done, busy}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b, eq, er;
    logic edbz, eovf;

    vecs.push_back('{8'd100,      8'd7,       8'd14,       8'd2,        1'b0, 1'b0});
    vecs.push_back('{8'(-100),    8'd7,       8'(-14),     8'(-2),      1'b0, 1'b0});
    vecs.push_back('{8'd100,      8'(-7),     8'(-14),     8'd2,        1'b0, 1'b0});
    vecs.push_back('{8'(-100),    8'(-7),     8'd14,       8'(-2),      1'b0, 1'b0});
    vecs.push_back('{8'd55,       8'd0,       8'hFF,       8'd55,       1'b1, 1'b0});
    vecs.push_back('{8'h80,       8'hFF,      8'h80,       8'd0,        1'b0, 1'b1});
    vecs.push_back('{8'h80,       8'd1,       8'h80,       8'd0,        1'b0, 1'b0});
    vecs.push_back('{8'd0,        8'd5,       8'd0,        8'd0,        1'b0, 1'b0});
    vecs.push_back('{8'd127,      8'h80,      8'd0,        8'd127,      1'b0, 1'b0});
    vecs.push_back('{8'h80,       8'h80,      8'd1,        8'd0,        1'b0, 1'b0});
    vecs.push_back('{8'h80,       8'd7,       8'(-18),     8'(-2),      1'b0, 1'b0});
    vecs.push_back('{8'h80,       8'd127,     8'hFF,       8'hFF,       1'b0, 1'b0});
    vecs.push_back('{8'd7,        8'd100,     8'd0,        8'd7,        1'b0, 1'b0});
    vecs.push_back('{8'hFF,       8'd2,       8'd0,        8'hFF,       1'b0, 1'b0});
    vecs.push_back('{8'h80,       8'd0,       8'hFF,       8'h80,       1'b1, 1'b0});

    start = 1'b0; dividend = '0; divisor = '0;
    rst_n = 1'b0;
    #1;
    check("reset outputs", {quotient, remainder, busy, done, div_by_zero, overflow}, '0);
    #20;
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
             vecs[i].dbz, vecs[i].ovf, 1'b0);

    // start while busy is ignored, then back-to-back request
    run_op("poke 100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 1'b1);
    run_op("b2b 9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of CALC
    @(negedge clk); dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset outputs", {quotient, remainder, busy, done, div_by_zero, overflow}, '0);
    prev_q = '0; prev_r = '0;
    @(negedge clk); rst_n = 1'b1;
    run_op("after reset 20/6", 8'd20, 8'd6, 8'd3, 8'd2, 1'b0, 1'b0, 1'b0);

    // start together with reset: request dropped
    @(negedge clk); rst_n = 1'b0; start = 1'b1; dividend = 8'd5; divisor = 8'd0;
    @(posedge clk); #1;
    check("start in reset", {busy, done, div_by_zero}, 3'b000);
    @(negedge clk); rst_n = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("start in reset dropped", {busy, done, div_by_zero, quotient}, '0);
    prev_q = '0; prev_r = '0;

    for (int k = 0; k < 150; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (k % 10 == 0) b = 8'($urandom_range(0, 2)) - 8'd1;
      if (k % 7 == 0) a = 8'h80;
      model(a, b, eq, er, edbz, eovf);
      run_op($sformatf("rnd %0h/%0h", a, b), a, b, eq, er, edbz, eovf, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
